// File: rtl/eq_coeff_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// eq_coeff_ctrl_pkg
// Definitions shared by the equalizer coefficient store and its controller:
//   - biquad band layout (5 coefficients per band) and per-coefficient offsets
//   - fixed-point headroom of the S3.(W-4) coefficient format
//   - bank-controller FSM state type
//   - helper telling whether a flat coefficient index addresses an a0 term
// -----------------------------------------------------------------------------
package eq_coeff_ctrl_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  // Offsets of the individual coefficients inside one band's group of five.
  localparam int K_A0 = 0;
  localparam int K_A1 = 1;
  localparam int K_A2 = 2;
  localparam int K_B1 = 3;
  localparam int K_B2 = 4;

  // Integer bits above the binary point (S3.x format).
  localparam int COEFF_HEADROOM = 3;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,  // filling both banks with unity coefficients
    ST_IDLE = 2'd1,  // host may write the shadow bank or commit
    ST_PEND = 2'd2,  // commit accepted, waiting for the equalizer to go idle
    ST_SYNC = 2'd3   // copying the new active bank into the shadow bank
  } eq_state_e;

  // Unity biquad: a0 = 1.0, every other term 0.
  function automatic logic is_a0_index(input int unsigned idx);
    return (idx % NR_EQ_BAND_COEFF) == K_A0;
  endfunction

endpackage

// File: rtl/eq_coeff_ram.sv
// -----------------------------------------------------------------------------
// eq_coeff_ram
// Two coefficient banks of DEPTH words each, one write port with a per-bank
// enable (both banks can take the same word in one cycle) and two synchronous
// read ports. Port 0 serves the equalizer, port 1 serves the bank copy.
// Ports:
//   clk         clock
//   wr_en_i     per-bank write enable, bit b writes bank b
//   wr_idx_i    write index inside the bank
//   wr_data_i   write data
//   rd0_bank_i  bank for read port 0
//   rd0_idx_i   index for read port 0
//   rd0_data_o  registered read data, port 0 (0 for an out-of-range index)
//   rd1_en_i    read enable, port 1 (data holds when low)
//   rd1_bank_i  bank for read port 1
//   rd1_idx_i   index for read port 1
//   rd1_data_o  registered read data, port 1
// -----------------------------------------------------------------------------
module eq_coeff_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 160,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic [1:0]       wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd0_bank_i,
  input  logic [AW-1:0]    rd0_idx_i,
  output logic [WIDTH-1:0] rd0_data_o,
  input  logic             rd1_en_i,
  input  logic             rd1_bank_i,
  input  logic [AW-1:0]    rd1_idx_i,
  output logic [WIDTH-1:0] rd1_data_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] rd0_q;
  logic [WIDTH-1:0] rd1_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_en_i[b] && (wr_idx_i <= LAST_IDX)) begin
        mem_q[b][wr_idx_i] <= wr_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd0_idx_i <= LAST_IDX) begin
      rd0_q <= mem_q[rd0_bank_i][rd0_idx_i];
    end else begin
      rd0_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rd1_en_i && (rd1_idx_i <= LAST_IDX)) begin
      rd1_q <= mem_q[rd1_bank_i][rd1_idx_i];
    end
  end

  assign rd0_data_o = rd0_q;
  assign rd1_data_o = rd1_q;

endmodule

// File: rtl/eq_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// eq_coeff_ctrl
// Coefficient store and bank controller for the multi-channel biquad
// equalizer. The equalizer reads the active bank; the host edits the shadow
// bank. A commit swaps banks only while the equalizer is idle, then copies the
// new active bank into the shadow so later host edits are incremental.
//
// Host handshake: cfg_wr and cfg_commit are taken in any cycle where cfg_rdy
// is high (IDLE only); there is no hold requirement and nothing is queued when
// cfg_rdy is low -- the host retries.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   eq_coeff_addr  equalizer coefficient index
//   eq_coeff       active-bank coefficient, one cycle after the address
//   eq_idle        equalizer has no sample in flight
//   cfg_wr         host write strobe into the shadow bank
//   cfg_addr       host coefficient index
//   cfg_data       host coefficient value
//   cfg_commit     host bank-swap request
//   cfg_rdy        high in IDLE only
//   cfg_err        one-cycle pulse after a write to an out-of-range index
//   swap_done      one-cycle pulse as the banks swap
//   active_bank    bank currently served to the equalizer
//   dbg_state      controller state, for observation
// -----------------------------------------------------------------------------
module eq_coeff_ctrl
  import eq_coeff_ctrl_pkg::*;
#(
  parameter  int NR_CHANNELS    = 4,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int AW             = $clog2(NR_EQ_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AW-1:0]             eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      eq_idle,
  input  logic                      cfg_wr,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [EQ_COEFF_WIDTH-1:0] cfg_data,
  input  logic                      cfg_commit,
  output logic                      cfg_rdy,
  output logic                      cfg_err,
  output logic                      swap_done,
  output logic                      active_bank,
  output eq_state_e                 dbg_state
);

  // cnt must reach NR_EQ_COEFF in SYNC (one extra cycle for the last write).
  localparam int CW = $clog2(NR_EQ_COEFF + 1);

  localparam logic [AW-1:0] LAST_IDX       = AW'(NR_EQ_COEFF - 1);
  localparam logic [CW-1:0] CNT_INIT_LAST  = CW'(NR_EQ_COEFF - 1);
  localparam logic [CW-1:0] CNT_SYNC_LAST  = CW'(NR_EQ_COEFF);
  localparam logic [EQ_COEFF_WIDTH-1:0] UNITY =
    EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 1 - COEFF_HEADROOM);

  eq_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                active_q, active_d;
  logic                swap_done_q, swap_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                eq_ok_q, eq_ok_d;

  logic [1:0]                wr_en;
  logic [AW-1:0]             wr_idx;
  logic [EQ_COEFF_WIDTH-1:0] wr_data;
  logic                      cp_rd_en;
  logic [AW-1:0]             cp_rd_idx;
  logic [EQ_COEFF_WIDTH-1:0] cp_rd_data;
  logic [EQ_COEFF_WIDTH-1:0] eq_rd_data;

  eq_coeff_ram #(
    .WIDTH (EQ_COEFF_WIDTH),
    .DEPTH (NR_EQ_COEFF),
    .AW    (AW)
  ) u_ram (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_data_i  (wr_data),
    .rd0_bank_i (active_q),
    .rd0_idx_i  (eq_coeff_addr),
    .rd0_data_o (eq_rd_data),
    .rd1_en_i   (cp_rd_en),
    .rd1_bank_i (active_q),
    .rd1_idx_i  (cp_rd_idx),
    .rd1_data_o (cp_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      swap_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      eq_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      swap_done_q <= swap_done_d;
      cfg_err_q   <= cfg_err_d;
      eq_ok_q     <= eq_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    swap_done_d = 1'b0;
    cfg_err_d   = 1'b0;
    eq_ok_d     = (eq_coeff_addr <= LAST_IDX);
    wr_en       = 2'b00;
    wr_idx      = '0;
    wr_data     = '0;
    cp_rd_en    = 1'b0;
    cp_rd_idx   = '0;

    unique case (state_q)
      ST_INIT: begin
        wr_en   = 2'b11;
        wr_idx  = AW'(cnt_q);
        wr_data = is_a0_index(int'(cnt_q)) ? UNITY : '0;
        if (cnt_q == CNT_INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_IDLE: begin
        if (cfg_wr) begin
          if (cfg_addr <= LAST_IDX) begin
            // Shadow bank is always the one not being served.
            wr_en   = active_q ? 2'b01 : 2'b10;
            wr_idx  = cfg_addr;
            wr_data = cfg_data;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (cfg_commit) begin
          state_d = ST_PEND;
        end
      end

      ST_PEND: begin
        if (eq_idle) begin
          active_d    = ~active_q;
          swap_done_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_SYNC;
        end
      end

      ST_SYNC: begin
        // Read word cnt now; write word cnt-1, whose read data arrived this
        // cycle. The extra cycle at cnt == NR_EQ_COEFF drains the last word.
        if (cnt_q < CNT_SYNC_LAST) begin
          cp_rd_en  = 1'b1;
          cp_rd_idx = AW'(cnt_q);
        end
        if (cnt_q != '0) begin
          wr_en   = active_q ? 2'b01 : 2'b10;
          wr_idx  = AW'(cnt_q - CW'(1));
          wr_data = cp_rd_data;
        end
        if (cnt_q == CNT_SYNC_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // eq_ok_q gates the RAM output so eq_coeff is 0 during reset and for
  // out-of-range addresses.
  assign eq_coeff    = eq_ok_q ? eq_rd_data : '0;
  assign cfg_rdy     = (state_q == ST_IDLE);
  assign cfg_err     = cfg_err_q;
  assign swap_done   = swap_done_q;
  assign active_bank = active_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
module tb_eq_coeff_ctrl;
  import eq_coeff_ctrl_pkg::*;

  localparam int N = 160;
  localparam logic [31:0] UNITY = 32'h1000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  eq_coeff_addr;
  logic [31:0] eq_coeff;
  logic        eq_idle;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_rdy;
  logic        cfg_err;
  logic        swap_done;
  logic        active_bank;
  eq_state_e   dbg_state;

  eq_coeff_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .eq_idle       (eq_idle),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_commit    (cfg_commit),
    .cfg_rdy       (cfg_rdy),
    .cfg_err       (cfg_err),
    .swap_done     (swap_done),
    .active_bank   (active_bank),
    .dbg_state     (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Banks as plain arrays; busy periods are edge countdowns; the shadow copy
  // is applied as a whole when the copy period ends (shadow is unobservable
  // in between, and host writes are refused then).
  logic [31:0] m_bank [2][N];
  bit          m_active, m_rdy, m_pend, m_syncing, m_err, m_swap, m_eq_chk;
  int          m_busy;
  logic [31:0] m_eq;

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        m_bank[b][i] = (i % 5 == 0) ? UNITY : 32'h0;
    m_active = 0; m_rdy = 0; m_pend = 0; m_syncing = 0;
    m_err = 0; m_swap = 0; m_eq_chk = 0; m_busy = N; m_eq = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_eq   = (eq_coeff_addr < N) ? m_bank[m_active][eq_coeff_addr] : 32'h0;
      m_err  = 0;
      m_swap = 0;
      if (m_rdy) begin
        m_eq_chk = 1;
        if (cfg_wr) begin
          if (cfg_addr < N) m_bank[!m_active][cfg_addr] = cfg_data;
          else m_err = 1;
        end
        if (cfg_commit) begin
          m_rdy  = 0;
          m_pend = 1;
        end
      end else if (m_pend) begin
        if (eq_idle) begin
          m_active  = !m_active;
          m_swap    = 1;
          m_pend    = 0;
          m_syncing = 1;
          m_busy    = N + 1;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_syncing)
            for (int i = 0; i < N; i++) m_bank[!m_active][i] = m_bank[m_active][i];
          m_syncing = 0;
          m_rdy     = 1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("cfg_rdy", cfg_rdy, m_rdy);
    check("cfg_err", cfg_err, m_err);
    check("swap_done", swap_done, m_swap);
    check("active_bank", active_bank, m_active);
    if (m_eq_chk) check("eq_coeff", eq_coeff, m_eq);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rdy(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (cfg_rdy) break;
    end
  endtask

  task automatic wait_swap(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (swap_done) break;
    end
  endtask

  task automatic read_lit(input string name, input logic [7:0] a, input logic [31:0] exp);
    eq_coeff_addr = a;
    @(negedge clk);
    check(name, eq_coeff, exp);
  endtask

  task automatic reset_lits();
    check("rst_cfg_rdy", cfg_rdy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_active", active_bank, 0);
    check("rst_eq_coeff", eq_coeff, 0);
    check("rst_state", dbg_state, ST_INIT);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    logic [7:0] rd_list [7];
    rd_list = '{8'd0, 8'd4, 8'd9, 8'd10, 8'd159, 8'd160, 8'd255};

    rst_n = 0; eq_coeff_addr = 0; eq_idle = 1; cfg_wr = 0;
    cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
    repeat (2) @(negedge clk);
    reset_lits();
    rst_n = 1;

    // 1: INIT length and unity contents
    wait_rdy(400, n);
    check("init_cycles", n, 160);
    read_lit("t1_a0", 8'd0, UNITY);
    read_lit("t1_a1", 8'd1, 32'h0);
    read_lit("t1_a5", 8'd5, UNITY);

    // 2: write + commit, swap one cycle after PEND entry
    cfg_wr = 1; cfg_addr = 8'd7; cfg_data = 32'h0123_4567;
    @(negedge clk);
    cfg_wr = 0; cfg_commit = 1; eq_coeff_addr = 8'd7;
    @(negedge clk);
    cfg_commit = 0;
    check("t2_pend_rdy", cfg_rdy, 0);
    check("t2_pend_noswap", swap_done, 0);
    @(negedge clk);
    check("t2_swap", swap_done, 1);
    check("t2_active", active_bank, 1);
    check("t2_old_bank_read", eq_coeff, 32'h0);

    // 4: write during SYNC ignored; SYNC lasts 161 cycles
    cfg_wr = 1; cfg_addr = 8'd3; cfg_data = 32'hDEAD_BEEF;
    @(negedge clk);
    cfg_wr = 0;
    check("t2_new_bank_read", eq_coeff, 32'h0123_4567);
    wait_rdy(400, n);
    check("sync_cycles", n + 1, 161);
    read_lit("t4_a7", 8'd7, 32'h0123_4567);

    // 3: commit held in PEND by eq_idle=0, second commit without writes
    eq_idle = 0; cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0;
    repeat (50) @(negedge clk);
    check("t3_held_active", active_bank, 1);
    check("t3_held_state", dbg_state, ST_PEND);
    check("t3_held_eq", eq_coeff, 32'h0123_4567);
    eq_idle = 1;
    @(negedge clk);
    check("t3_swap", swap_done, 1);
    check("t3_active", active_bank, 0);
    wait_rdy(400, n);
    check("sync_cycles2", n, 161);
    read_lit("t4_copy_a7", 8'd7, 32'h0123_4567);
    read_lit("t4_sync_wr_ignored", 8'd3, 32'h0);
    read_lit("t4_b0_a0", 8'd0, UNITY);
    read_lit("t4_b0_a1", 8'd1, 32'h0);
    read_lit("t4_b0_a5", 8'd5, UNITY);

    // 5: invalid write address, then write+commit in one cycle
    cfg_wr = 1; cfg_addr = 8'd200; cfg_data = 32'h5555_AAAA;
    @(negedge clk);
    cfg_wr = 0;
    check("t5_err_pulse", cfg_err, 1);
    @(negedge clk);
    check("t5_err_clear", cfg_err, 0);
    read_lit("t5_oor_read", 8'd200, 32'h0);
    cfg_wr = 1; cfg_addr = 8'd10; cfg_data = 32'hCAFE_F00D; cfg_commit = 1;
    eq_coeff_addr = 8'd10;
    @(negedge clk);
    cfg_wr = 0; cfg_commit = 0;
    wait_swap(1, n);
    check("t5_swap_latency", swap_done, 1);
    read_lit("t5_wr_commit", 8'd10, 32'hCAFE_F00D);
    for (int i = 0; i < 7; i++) begin
      eq_coeff_addr = rd_list[i];
      @(negedge clk);
    end

    // 6: reset during SYNC at cnt=80
    repeat (72) @(negedge clk);
    check("t6_in_sync", dbg_state, ST_SYNC);
    #1 rst_n = 0;
    #1 reset_lits();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    wait_rdy(400, n);
    check("reinit_cycles", n, 160);
    check("t6_active", active_bank, 0);
    read_lit("t6_a10", 8'd10, UNITY);
    read_lit("t6_a7", 8'd7, 32'h0);
    read_lit("t6_a0", 8'd0, UNITY);
    read_lit("t6_a159", 8'd159, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
